// File: rtl/collision_pkg.sv
// collision_pkg: shared constants and collision code encoding for the
// collision map lookup port.
//   COLL_DATA_W / COLL_ADDR_W / COLL_DEPTH : default map geometry (640x480)
//   collision_code_t                       : meaning of each stored code
package collision_pkg;

  localparam int unsigned COLL_DATA_W = 3;
  localparam int unsigned COLL_ADDR_W = 19;
  localparam int unsigned COLL_DEPTH  = 307200;

  typedef enum logic [COLL_DATA_W-1:0] {
    EMPTY      = 3'd0,
    WALL       = 3'd1,
    WATER      = 3'd2,
    LAVA       = 3'd3,
    GOO        = 3'd4,
    EXIT_FIRE  = 3'd5,
    EXIT_WATER = 3'd6,
    RAMP       = 3'd7
  } collision_code_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant selection.
//   req      in  N   requesting channels
//   ptr      in  PW  channel with highest priority this cycle
//   grant    out N   one-hot grant, or zero when nothing requests
//   next_ptr out PW  channel after the granted one (ptr when no grant)
module rr_arbiter #(
  parameter  int unsigned N  = 2,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] next_ptr
);

  logic        found;
  int unsigned idx;

  // Scan channels starting at ptr and wrapping; first requester wins.
  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        next_ptr   = PW'((idx + 1) % N);
      end
    end
  end

endmodule

// File: rtl/collision_map_port.sv
// collision_map_port: multi-channel collision map lookup.
// Channels request pixel lookups over valid/ready; a round-robin arbiter
// grants one per cycle into the single registered read port, and each
// channel owns a one-entry response register with its own backpressure.
// Addresses >= DEPTH return OOB_CODE without touching memory.
//   clock, reset           : system clock, synchronous active-high reset
//   req_valid/addr/ready   : per-channel lookup request (addr i at [i*ADDR_W +: ADDR_W])
//   rsp_valid/data/ready   : per-channel response register
// Optional macro COLLISION_MAP_WRITE_EN adds wr_en/wr_addr/wr_data for
// dynamic tiles; a write blocks all grants in its cycle.
module collision_map_port
  import collision_pkg::*;
#(
  parameter int unsigned       DATA_W    = COLL_DATA_W,
  parameter int unsigned       ADDR_W    = COLL_ADDR_W,
  parameter int unsigned       DEPTH     = COLL_DEPTH,
  parameter int unsigned       NUM_CH    = 2,
  parameter                    INIT_FILE = "collision.COE",
  parameter logic [DATA_W-1:0] OOB_CODE  = WALL
) (
  input  logic                     clock,
  input  logic                     reset,
`ifdef COLLISION_MAP_WRITE_EN
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
`endif
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  output logic [NUM_CH-1:0]        req_ready,
  output logic [NUM_CH-1:0]        rsp_valid,
  output logic [NUM_CH*DATA_W-1:0] rsp_data,
  input  logic [NUM_CH-1:0]        rsp_ready
);

  localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Map image is attached to the RAM by the implementation flow.
  if (INIT_FILE == "") begin : g_blank_map
  end

  logic [DATA_W-1:0] map_mem [DEPTH];

  logic [PTR_W-1:0]  ptr_q, ptr_d, next_ptr;
  logic [NUM_CH-1:0] eligible, grant;
  logic [NUM_CH-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q [NUM_CH];
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_in_range;
  logic              wr_block;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

`ifdef COLLISION_MAP_WRITE_EN
  assign wr_block  = wr_en;
  assign mem_we    = wr_en && (32'(wr_addr) < DEPTH);
  assign mem_waddr = wr_addr;
  assign mem_wdata = wr_data;
`else
  // Read-only map: the write path is tied off so the array infers as ROM.
  assign wr_block  = 1'b0;
  assign mem_we    = 1'b0;
  assign mem_waddr = '0;
  assign mem_wdata = '0;
`endif

  // A stalled response register blocks its own channel only.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      eligible[i] = req_valid[i] && (!rsp_valid_q[i] || rsp_ready[i]) &&
                    !reset && !wr_block;
    end
  end

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .req      (eligible),
    .ptr      (ptr_q),
    .grant    (grant),
    .next_ptr (next_ptr)
  );

  assign req_ready = grant;

  always_comb begin
    rd_addr = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant[i]) rd_addr = req_addr[i*ADDR_W +: ADDR_W];
    end
    rd_in_range = (32'(rd_addr) < DEPTH);
    ptr_d       = (|grant) ? next_ptr : ptr_q;
    // A same-cycle grant refills the register, so it never drains.
    rsp_valid_d = grant | (rsp_valid_q & ~rsp_ready);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q       <= '0;
      rsp_valid_q <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) rsp_data_q[i] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (grant[i]) rsp_data_q[i] <= rd_in_range ? map_mem[rd_addr] : OOB_CODE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) map_mem[mem_waddr] <= mem_wdata;
  end

  assign rsp_valid = rsp_valid_q;

  always_comb begin
    rsp_data = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      rsp_data[i*DATA_W +: DATA_W] = rsp_data_q[i];
    end
  end

endmodule

// File: tb/tb_collision_map_port.sv
// tb_collision_map_port: self-checking bench for collision_map_port (2 channels).
// The reference model tracks expected grants, response registers and map
// contents directly from the lookup rules; the map is preloaded at time 0.
module tb_collision_map_port;

  localparam int AW    = 19;
  localparam int DW    = 3;
  localparam int DEPTH = 307200;

  logic          clock;
  logic          reset;
  logic [1:0]    req_valid;
  logic [2*AW-1:0] req_addr;
  logic [1:0]    req_ready;
  logic [1:0]    rsp_valid;
  logic [2*DW-1:0] rsp_data;
  logic [1:0]    rsp_ready;
`ifdef COLLISION_MAP_WRITE_EN
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
`endif

  collision_map_port dut (
    .clock     (clock),
    .reset     (reset),
`ifdef COLLISION_MAP_WRITE_EN
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
`endif
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state
  logic [DW-1:0] ref_mem [int unsigned];
  int            m_ptr;
  bit            m_vld [2];
  logic [DW-1:0] m_data [2];

  function automatic logic [DW-1:0] expect_code(input logic [AW-1:0] a);
    if (int'(a) >= DEPTH) return 3'b001;
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return 3'b000;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 15) == 0) return AW'(DEPTH + $urandom_range(0, 1000));
    return AW'($urandom_range(0, 63));
  endfunction

  // One clock: check grant before the edge, advance the model at the edge,
  // check response registers just after it. Returns the expected grant (-1 none).
  task automatic cycle(output int g);
    logic [1:0]    exp_rdy;
    logic [AW-1:0] g_addr;
    bit            wr_on;
    logic [AW-1:0] w_a;
    logic [DW-1:0] w_d;
    wr_on = 1'b0;
    w_a   = '0;
    w_d   = '0;
`ifdef COLLISION_MAP_WRITE_EN
    wr_on = wr_en;
    w_a   = wr_addr;
    w_d   = wr_data;
`endif
    @(negedge clock);
    g = -1;
    if (!reset && !wr_on) begin
      for (int k = 0; k < 2; k++) begin
        int c;
        c = (m_ptr + k) % 2;
        if (g < 0 && req_valid[c] && (!m_vld[c] || rsp_ready[c])) g = c;
      end
    end
    exp_rdy = (g >= 0) ? (2'b01 << g) : 2'b00;
    g_addr  = (g >= 0) ? req_addr[g*AW +: AW] : '0;
    n_chk++;
    assert (req_ready === exp_rdy)
      else begin n_fail++; $error("FAIL req_ready: observed %b expected %b", req_ready, exp_rdy); end
    @(posedge clock);
    if (reset) begin
      m_ptr = 0;
      for (int c = 0; c < 2; c++) begin m_vld[c] = 1'b0; m_data[c] = '0; end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (c == g) begin
          m_vld[c]  = 1'b1;
          m_data[c] = expect_code(g_addr);
        end else if (rsp_ready[c]) begin
          m_vld[c] = 1'b0;
        end
      end
      if (g >= 0) m_ptr = (g + 1) % 2;
    end
    if (wr_on && int'(w_a) < DEPTH) ref_mem[int'(w_a)] = w_d;
    #1;
    for (int c = 0; c < 2; c++) begin
      n_chk++;
      assert (rsp_valid[c] === m_vld[c])
        else begin n_fail++; $error("FAIL rsp_valid[%0d]: observed %b expected %b", c, rsp_valid[c], m_vld[c]); end
      n_chk++;
      assert (rsp_data[c*DW +: DW] === m_data[c])
        else begin n_fail++; $error("FAIL rsp_data[%0d]: observed %0d expected %0d", c, rsp_data[c*DW +: DW], m_data[c]); end
    end
  endtask

  initial begin
    int g;
    logic [DW-1:0] v;

    m_ptr = 0;
    for (int c = 0; c < 2; c++) begin m_vld[c] = 1'b0; m_data[c] = '0; end
    // Preload the low part of the map; address 0 holds EMPTY.
    for (int i = 0; i < 64; i++) begin
      v = (i == 0) ? 3'd0 : DW'($urandom_range(0, 7));
      ref_mem[i]      = v;
      dut.map_mem[i]  = v;
    end

    reset     = 1'b1;
    req_valid = 2'b11;
    req_addr  = '0;
    rsp_ready = 2'b00;
`ifdef COLLISION_MAP_WRITE_EN
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
`endif

    // Reset: no grants even with requests pending, outputs cleared.
    cycle(g);
    cycle(g);

    // Single lookup of address 0 (EMPTY) on ch0.
    reset     = 1'b0;
    req_valid = 2'b01;
    req_addr  = '0;
    rsp_ready = 2'b11;
    cycle(g);
    req_valid = 2'b00;
    cycle(g);

    // Both channels streaming: grants alternate, one lookup per cycle.
    req_valid = 2'b11;
    for (int n = 0; n < 8; n++) begin
      cycle(g);
      if (g >= 0) req_addr[g*AW +: AW] = AW'($urandom_range(1, 63));
    end

    // ch1 response stalled: ch0 keeps being served, ch1 data held.
    rsp_ready = 2'b01;
    for (int n = 0; n < 6; n++) begin
      cycle(g);
      if (g >= 0) req_addr[g*AW +: AW] = AW'($urandom_range(1, 63));
    end
    rsp_ready = 2'b11;
    for (int n = 0; n < 3; n++) cycle(g);

    // Out-of-range addresses: first past the end, then the top of the range.
    req_valid = 2'b01;
    req_addr  = '0;
    req_addr[0 +: AW] = AW'(DEPTH);
    cycle(g);
    req_addr[0 +: AW] = '1;
    cycle(g);
    req_valid = 2'b00;
    cycle(g);

    // Reset right after a grant: responses discarded, pointer back to ch0.
    req_valid = 2'b01;
    req_addr[0 +: AW] = AW'(5);
    cycle(g);
    reset = 1'b1;
    cycle(g);
    reset     = 1'b0;
    req_valid = 2'b11;
    req_addr[AW +: AW] = AW'(7);
    cycle(g);
    req_valid = 2'b00;
    cycle(g);

`ifdef COLLISION_MAP_WRITE_EN
    // Write of LAVA blocks the grant, then a later read returns it.
    req_valid = 2'b01;
    req_addr[0 +: AW] = AW'(1000);
    wr_en   = 1'b1;
    wr_addr = AW'(1000);
    wr_data = 3'd3;
    cycle(g);
    wr_en = 1'b0;
    cycle(g);
    // Out-of-range write is dropped.
    wr_en   = 1'b1;
    wr_addr = AW'(DEPTH);
    wr_data = 3'd6;
    cycle(g);
    wr_en = 1'b0;
    req_addr[0 +: AW] = AW'(DEPTH);
    cycle(g);
    req_valid = 2'b00;
    cycle(g);
`endif

    // Random traffic: requesters hold valid/address until granted.
    g = -1;
    for (int n = 0; n < 300; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (!req_valid[c] || g == c) begin
          req_valid[c] = ($urandom_range(0, 3) != 0);
          req_addr[c*AW +: AW] = rand_addr();
        end
      end
      rsp_ready = 2'($urandom_range(0, 3));
`ifdef COLLISION_MAP_WRITE_EN
      wr_en   = ($urandom_range(0, 7) == 0);
      wr_addr = AW'($urandom_range(0, 63));
      wr_data = DW'($urandom_range(0, 7));
`endif
      cycle(g);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/collision_map_port.md
Name: collision_map_port

Overview:
- Multi-channel, parametrised collision-map memory that replaces the single-port collision ROM.
- Several clients (Fireboy, Watergirl, projectile/box logic) issue pixel-address lookups over valid/ready.
- A round-robin arbiter grants one lookup per cycle into a single block-RAM read port.
- Each channel gets its result in a one-entry response register with its own backpressure.

Parameters:
- DATA_W, 3, width of one collision code.
- ADDR_W, 19, address width.
- DEPTH, 307200, number of map entries (640x480).
- NUM_CH, 2, number of request channels (1..8).
- INIT_FILE, "collision.COE", memory initialisation file.
- OOB_CODE, 3'b001, code returned for address >= DEPTH (treated as solid wall).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_CH  per-channel lookup request
- req_addr  in  NUM_CH*ADDR_W  per-channel address; channel i at bits [i*ADDR_W +: ADDR_W]
- req_ready  out  NUM_CH  per-channel grant; one-hot or zero
- rsp_valid  out  NUM_CH  response register full
- rsp_data  out  NUM_CH*DATA_W  per-channel collision code
- rsp_ready  in  NUM_CH  consumer accepts response

Behaviour:
- Reset (synchronous, active-high):
  - rsp_valid = 0, rsp_data = 0, req_ready = 0.
  - Round-robin pointer = 0.
  - Any in-flight lookup is discarded.
  - Memory contents are not cleared.
- Eligibility: channel i is eligible when req_valid[i] && (!rsp_valid[i] || rsp_ready[i]).
- Arbitration:
  - Round-robin over eligible channels, starting at the pointer.
  - req_ready is combinational from req_valid, rsp_valid, rsp_ready and the pointer; at most one bit is set.
  - After a grant to channel g, the pointer becomes (g+1) mod NUM_CH.
  - With no grant, the pointer holds.
- Handshake: a request completes on req_valid[i] && req_ready[i]. The requester holds valid and address stable until granted.
- Latency: a grant in cycle T gives rsp_valid[g] = 1 and rsp_data[g] = memory[addr] from cycle T+1. This is exactly one clock; the memory is a registered read.
- Response drain:
  - rsp_valid[i] clears on rsp_ready[i] unless the same channel is granted in that same cycle; in that case it stays 1 and the data is replaced.
  - Back-to-back grants to one channel therefore sustain 1 lookup/cycle.
- Out of range: an address >= DEPTH does not index memory; the response is OOB_CODE with the same latency.
- A channel whose response is stalled (rsp_valid=1, rsp_ready=0) is never granted. Other channels are unaffected.
- With only one eligible channel, it is granted every cycle regardless of the pointer.
- rsp_data is held stable while rsp_valid=1 and not drained.

Optional Feature:
COLLISION_MAP_WRITE_EN
- Defined:
  - Adds ports wr_en (in, 1), wr_addr (in, ADDR_W) and wr_data (in, DATA_W) for dynamic tiles (doors, moving platforms).
  - A write has priority: in a cycle with wr_en=1, req_ready = 0 for all channels and the pointer holds.
  - The write commits at the clock edge. A lookup granted in any later cycle to the same address returns wr_data.
  - A write with wr_addr >= DEPTH is ignored.
- Undefined: the write ports are absent, and the memory is read-only (ROM inferred from INIT_FILE).

Decomposition:
- Package collision_pkg holds:
  - constants COLL_DATA_W, COLL_ADDR_W, COLL_DEPTH;
  - enum collision_code_t: EMPTY=0, WALL=1, WATER=2, LAVA=3, GOO=4, EXIT_FIRE=5, EXIT_WATER=6, RAMP=7.
- Sub-module rr_arbiter (parameter N): inputs req[N] and the pointer; outputs grant[N] and next_ptr.

Test Plan:
- Reset, then ch0 requests addr 0 holding EMPTY -> req_ready[0]=1 in that cycle; the next cycle shows rsp_valid[0]=1, rsp_data[0]=0.
- ch0 and ch1 both assert valid continuously with rsp_ready=1 -> grants alternate 0,1,0,1 (pointer starts at 0); each response appears 1 cycle after its grant.
- ch1 with rsp_ready[1]=0 and response full, ch0 active -> ch0 is granted every cycle; ch1 stays ungranted and its rsp_data is unchanged until rsp_ready[1]=1.
- ch0 addr 307200 -> rsp_data[0]=3'b001 after 1 cycle, with no memory access.
- reset asserted the cycle after a grant -> the next cycle shows rsp_valid=0, and the next grant goes to ch0.
- With COLLISION_MAP_WRITE_EN: write LAVA to 1000 while ch0 requests -> no grant that cycle; the next cycle, ch0 reads 1000 and gets 3.
